axi4_rd_initiator: RTL and testbench

Synthesizable AXI4 read-channel initiator: accepts a single burst read command on a valid/ready command port, issues it on AR, collects the R beats through a 2-entry buffer, and streams them out with per-beat response and a last flag. It is the requesting end of the AR/R channels and pairs with the read-responding side of the AXI4 agent in the co-simulation bench. One transaction is outstanding at a time; write channels are out of scope.

---
 rtl/axi4_rd_pkg.sv | 37 +++
 rtl/axi4_rd_fifo.sv | 49 ++++
 rtl/axi4_rd_initiator.sv | 166 ++++++++++++++++
 tb/tb_axi4_rd_initiator.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_rd_pkg.sv
// Shared types and constants for the AXI4 read initiator.
// Burst/response encodings, FSM state codes, fixed AR attributes.
package axi4_rd_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_t;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t ST_IDLE  = 2'd0;
    localparam rd_state_t ST_ADDR  = 2'd1;
    localparam rd_state_t ST_DATA  = 2'd2;
    localparam rd_state_t ST_DRAIN = 2'd3;

    localparam logic       AR_LOCK   = 1'b0;
    localparam logic [3:0] AR_CACHE  = 4'b0011;
    localparam logic [2:0] AR_PROT   = 3'b000;
    localparam logic [3:0] AR_QOS    = 4'b0000;
    localparam logic [3:0] AR_REGION = 4'b0000;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_rd_fifo.sv
// Two-entry registered FIFO between the R channel and the dout port.
// Push is ignored while full, pop is ignored while empty.
module axi4_rd_fifo
    import axi4_rd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign dout    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (do_pop)
                rptr <= ~rptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/axi4_rd_initiator.sv
// AXI4 read-channel initiator: one burst at a time, AR issue,
// R collection through a 2-entry buffer, beat streaming on dout.
module axi4_rd_initiator
    import axi4_rd_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [1:0]        cmd_burst,
    input  logic [ID_W-1:0]   cmd_id,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [1:0]        arburst,
    output logic [2:0]        arsize,
    output logic              arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic [3:0]        arqos,
    output logic [3:0]        arregion,
    output logic              arvalid,
    input  logic              arready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic [1:0]        dout_resp,
    output logic              dout_last,
    output logic              done,
    output logic              err_cmd,
    output logic              err_last,
    output logic              err_id,
    output logic              err_resp
);

    localparam int          FW         = DATA_W + 3;
    localparam logic [2:0]  ARSIZE     = 3'($clog2(DATA_W / 8));
    localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(DATA_W / 8 - 1);

    rd_state_t   state;
    logic [8:0]  beat_cnt;
    logic        cmd_hs;
    logic        cmd_bad;
    logic        r_hs;
    logic        last_exp;
    logic        pop;
    logic        full;
    logic        empty;
    logic [FW-1:0] f_din;
    logic [FW-1:0] f_dout;

    assign arsize   = ARSIZE;
    assign arlock   = AR_LOCK;
    assign arcache  = AR_CACHE;
    assign arprot   = AR_PROT;
    assign arqos    = AR_QOS;
    assign arregion = AR_REGION;

    assign cmd_ready  = (state == ST_IDLE);
    assign arvalid    = (state == ST_ADDR);
    assign rready     = (state == ST_DATA) && !full;
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign r_hs       = rvalid && rready;
    assign last_exp   = (beat_cnt == 9'd1);
    assign dout_valid = !empty;
    assign pop        = dout_valid && dout_ready;

    // WRAP needs a power-of-two length and a size-aligned start.
    assign cmd_bad = (cmd_burst == BURST_RSVD) ||
                     ((cmd_burst == BURST_WRAP) &&
                      (!wrap_len_ok(cmd_len) ||
                       ((cmd_addr & AMASK) != '0)));

    assign f_din     = {rdata, rresp, last_exp};
    assign dout_data = f_dout[FW-1:3];
    assign dout_resp = f_dout[2:1];
    assign dout_last = f_dout[0];

    axi4_rd_fifo #(
        .W (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_hs),
        .pop   (pop),
        .din   (f_din),
        .dout  (f_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= 9'd0;
            arid     <= '0;
            araddr   <= '0;
            arlen    <= 8'd0;
            arburst  <= 2'd0;
            done     <= 1'b0;
            err_cmd  <= 1'b0;
            err_last <= 1'b0;
            err_id   <= 1'b0;
            err_resp <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        arid     <= cmd_id;
                        araddr   <= cmd_addr;
                        arlen    <= cmd_len;
                        arburst  <= cmd_burst;
                        beat_cnt <= {1'b0, cmd_len} + 9'd1;
                        err_cmd  <= cmd_bad;
                        err_last <= 1'b0;
                        err_id   <= 1'b0;
                        err_resp <= 1'b0;
                        if (cmd_bad)
                            done <= 1'b1;
                        else
                            state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready)
                        state <= ST_DATA;
                end
                ST_DATA: begin
                    // Length is counted locally; rlast only feeds err_last.
                    if (r_hs) begin
                        beat_cnt <= beat_cnt - 9'd1;
                        if (rlast != last_exp)
                            err_last <= 1'b1;
                        if (rid != arid)
                            err_id <= 1'b1;
                        if (rresp[1])
                            err_resp <= 1'b1;
                        if (last_exp)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && dout_last) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_rd_initiator.sv
// Scoreboard bench for axi4_rd_initiator: R beats queue expected
// dout words, a negedge monitor pops and compares them.
module tb_axi4_rd_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_id;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic [3:0]  arregion;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic [1:0]  dout_resp;
    logic        dout_last;
    logic        done;
    logic        err_cmd;
    logic        err_last;
    logic        err_id;
    logic        err_resp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [34:0] q[$];
    bit          mon_en = 1'b0;
    bit          in_data = 1'b0;
    int          occ = 0;
    int          beats_left = 0;
    int          ar_cycles = 0;
    int          ar_hs = 0;
    int          pops = 0;
    int          last_pop_cyc = -10;
    int          first_pop_cyc = 0;
    bit          first_pend = 1'b0;
    bit          stall_seen = 1'b0;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic [1:0]  e_burst;
    logic [3:0]  e_id;

    logic [31:0] b_data [16];
    logic [1:0]  b_resp [16];
    logic        b_last [16];
    logic [3:0]  b_id   [16];

    axi4_rd_initiator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_burst  (cmd_burst),
        .cmd_id     (cmd_id),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arburst    (arburst),
        .arsize     (arsize),
        .arlock     (arlock),
        .arcache    (arcache),
        .arprot     (arprot),
        .arqos      (arqos),
        .arregion   (arregion),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_resp  (dout_resp),
        .dout_last  (dout_last),
        .done       (done),
        .err_cmd    (err_cmd),
        .err_last   (err_last),
        .err_id     (err_id),
        .err_resp   (err_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [34:0] e;
        if (mon_en && rst_n) begin
            if (arvalid) begin
                ar_cycles++;
                chk("araddr", araddr, e_addr);
                chk("arlen", arlen, e_len);
                chk("arburst", arburst, e_burst);
                chk("arid", arid, e_id);
                chk("arsize", arsize, 3'd2);
                if (arready) ar_hs++;
            end
            chk("rready", rready, in_data && occ < 2);
            chk("dout_valid", dout_valid, occ != 0);
            if (in_data && !rready) stall_seen = 1'b1;
            if (dout_valid && dout_ready) begin
                if (q.size() == 0) begin
                    chk("dout_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("dout", {dout_data, dout_resp, dout_last}, e);
                    if (e[0]) last_pop_cyc = cyc;
                end
                if (first_pend) begin
                    first_pop_cyc = cyc;
                    first_pend = 1'b0;
                end
                pops++;
                occ--;
            end
            if (rvalid && rready) begin
                q.push_back({rdata, rresp, beats_left == 1});
                occ++;
                beats_left--;
                if (beats_left == 0) in_data = 1'b0;
            end
            if (arvalid && arready) in_data = 1'b1;
        end
    end

    task automatic set_beats(input int n, input logic [31:0] base,
                             input logic [3:0] id);
        for (int i = 0; i < 16; i++) begin
            b_data[i] = base + 32'(i);
            b_resp[i] = 2'd0;
            b_last[i] = (i == n - 1);
            b_id[i]   = id;
        end
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l,
                            input logic [1:0] b, input logic [3:0] id);
        int t;
        e_addr = a;
        e_len = l;
        e_burst = b;
        e_id = id;
        beats_left = int'(l) + 1;
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_len = l;
        cmd_burst = b;
        cmd_id = id;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("cmd_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic ar_phase(input int d);
        arready = 1'b0;
        repeat (d) begin
            @(posedge clk);
            #1;
        end
        arready = 1'b1;
        @(posedge clk);
        #1;
        arready = 1'b0;
    endtask

    task automatic run_r(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            rvalid = 1'b1;
            rdata = b_data[i];
            rresp = b_resp[i];
            rlast = b_last[i];
            rid = b_id[i];
            t = 0;
            @(negedge clk);
            while (!rready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk("rready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        rvalid = 1'b0;
        rlast = 1'b0;
    endtask

    task automatic stall_proc();
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dout_ready = 1'b1;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk);
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
        chk("done_timing", cyc, last_pop_cyc + 1);
        chk("done_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [31:0] a, input logic [7:0] l,
                       input logic [1:0] b, input logic [3:0] id,
                       input int ard, input bit stall);
        first_pend = 1'b1;
        send_cmd(a, l, b, id);
        ar_phase(ard);
        if (stall) begin
            fork
                stall_proc();
            join_none
        end
        run_r(int'(l) + 1);
        wait_done();
    endtask

    task automatic bad_cmd(input logic [31:0] a, input logic [7:0] l,
                           input logic [1:0] b, string tag);
        int arc;
        arc = ar_cycles;
        send_cmd(a, l, b, 4'd0);
        @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err_cmd"}, err_cmd, 1);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_no_ar"}, ar_cycles, arc);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_dout_valid"}, dout_valid, 0);
        chk({tag, "_dout"}, {dout_data, dout_resp, dout_last}, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_errs"}, {err_cmd, err_last, err_id, err_resp}, 0);
        chk({tag, "_ar"}, {arid, araddr, arlen, arburst}, 0);
        chk({tag, "_arconst"},
            {arsize, arlock, arcache, arprot, arqos, arregion},
            {3'd2, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0});
    endtask

    initial begin
        int p0;
        int a0;
        int h0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        cmd_burst = '0;
        cmd_id = '0;
        arready = 1'b0;
        rvalid = 1'b0;
        rid = '0;
        rdata = '0;
        rresp = '0;
        rlast = 1'b0;
        dout_ready = 1'b1;
        #12;
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        set_beats(4, 32'hA0, 4'd5);
        p0 = pops;
        h0 = ar_hs;
        txn(32'h1000, 8'd3, 2'd1, 4'd5, 0, 1'b0);
        chk("t1_beats", pops - p0, 4);
        chk("t1_back_to_back", last_pop_cyc - first_pop_cyc, 3);
        chk("t1_ar_hs", ar_hs - h0, 1);
        chk("t1_errs", {err_cmd, err_last, err_id, err_resp}, 0);

        set_beats(2, 32'hB0, 4'd3);
        a0 = ar_cycles;
        h0 = ar_hs;
        txn(32'h2000, 8'd1, 2'd1, 4'd3, 3, 1'b0);
        chk("t2_ar_cycles", ar_cycles - a0, 4);
        chk("t2_ar_hs", ar_hs - h0, 1);

        set_beats(8, 32'hC0, 4'd1);
        p0 = pops;
        stall_seen = 1'b0;
        txn(32'h3000, 8'd7, 2'd1, 4'd1, 0, 1'b1);
        chk("t3_beats", pops - p0, 8);
        chk("t3_rready_drop", stall_seen, 1);
        chk("t3_q_empty", q.size(), 0);

        bad_cmd(32'h4000, 8'd2, 2'd2, "wrap_len2");
        bad_cmd(32'h1002, 8'd3, 2'd2, "wrap_unaligned");
        bad_cmd(32'h4000, 8'd0, 2'd3, "rsvd_burst");
        set_beats(4, 32'hD0, 4'd6);
        txn(32'h5008, 8'd3, 2'd2, 4'd6, 0, 1'b0);
        chk("wrap_ok_err_cmd", err_cmd, 0);

        set_beats(4, 32'hE0, 4'd2);
        b_last[1] = 1'b1;
        b_last[3] = 1'b0;
        p0 = pops;
        txn(32'h6000, 8'd3, 2'd1, 4'd2, 1, 1'b0);
        chk("t5_err_last", err_last, 1);
        chk("t5_beats", pops - p0, 4);

        set_beats(2, 32'hF0, 4'd4);
        b_resp[0] = 2'd2;
        txn(32'h7000, 8'd1, 2'd1, 4'd4, 0, 1'b0);
        chk("t6_err_resp", err_resp, 1);
        set_beats(1, 32'h11, 4'd7);
        b_id[0] = 4'd9;
        send_cmd(32'h8000, 8'd0, 2'd1, 4'd7);
        @(negedge clk);
        chk("t6_err_resp_clr", err_resp, 0);
        @(posedge clk);
        #1;
        ar_phase(0);
        run_r(1);
        wait_done();
        chk("t7_err_id", err_id, 1);
        chk("t7_err_resp", err_resp, 0);

        mon_en = 1'b0;
        set_beats(8, 32'h90, 4'd2);
        dout_ready = 1'b0;
        send_cmd(32'h9000, 8'd7, 2'd1, 4'd2);
        ar_phase(0);
        run_r(2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dout_ready = 1'b1;
        q.delete();
        occ = 0;
        in_data = 1'b0;
        beats_left = 0;
        @(negedge clk);
        chk_idle_outputs("postreset");
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        set_beats(2, 32'h55, 4'd1);
        p0 = pops;
        txn(32'hA000, 8'd1, 2'd1, 4'd1, 0, 1'b0);
        chk("recover_beats", pops - p0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
